// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED rotator controller.
package led_ctrl_pkg;

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned CNT_W   = 32;

    localparam int unsigned BTN_RUN  = 0;
    localparam int unsigned BTN_STEP = 1;
    localparam int unsigned BTN_DIR  = 2;
    localparam int unsigned BTN_LOAD = 3;
    localparam int unsigned BTN_DEF  = 4;

    localparam logic [LED_W-1:0] LED_DEFAULT = 8'h01;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        STEP  = 2'd2
    } mode_t;

    // Step period for a speed setting; never below one cycle.
    function automatic logic [CNT_W-1:0] step_period(input logic [CNT_W-1:0] base,
                                                     input logic [2:0]       speed);
        logic [CNT_W-1:0] p;
        p = base >> speed;
        return (p == '0) ? CNT_W'(1) : p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, optional debouncer, rising-edge press pulse.
// Debouncer present only when LED_CTRL_DEBOUNCE_EN is defined.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    if (DEB_CYCLES < 2) begin : g_deb_chk
        $error("btn_debounce: DEB_CYCLES must be at least 2");
    end

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic press_q;
    logic press_d;
    logic level;

`ifdef LED_CTRL_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);

    logic             stable_q;
    logic             stable_d;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync_q != stable_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                stable_d = sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level = stable_q;
`else
    assign level = sync_q;
`endif

    always_comb begin
        press_d = level & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= btn_raw;
            sync_q  <= meta_q;
            prev_q  <= level;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_ctrl.sv
// Command sequencer for the rotating LED datapath: step timing, direction, run/pause and loads.
// Define LED_CTRL_DEBOUNCE_EN to debounce the buttons.
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic [LED_W-1:0] sw,
    output logic             step,
    output logic             dir,
    output logic             load,
    output logic [LED_W-1:0] load_val,
    output logic [1:0]       mode
);

    logic [NUM_BTN-1:0] press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn[i]),
            .press  (press[i])
        );
    end

    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_c;
    logic             step_q, step_d;
    logic             load_q, load_d;
    logic             dir_q, dir_d;
    logic [LED_W-1:0] load_val_q, load_val_d;

    always_comb begin
        mode_d     = mode_q;
        cnt_d      = '0;
        step_d     = 1'b0;
        load_d     = 1'b0;
        load_val_d = load_val_q;
        dir_d      = dir_q ^ press[BTN_DIR];
        period_c   = step_period(CNT_W'(TICK_DIV), sw[2:0]);

        // >= lets a shortened period take effect without wrapping the counter.
        case (mode_q)
            RUN: begin
                if (press[BTN_RUN]) begin
                    mode_d = PAUSE;
                end else if (cnt_q >= period_c - CNT_W'(1)) begin
                    step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PAUSE: begin
                if (press[BTN_RUN]) begin
                    mode_d = RUN;
                end else if (press[BTN_STEP]) begin
                    mode_d = STEP;
                    step_d = 1'b1;
                end
            end
            STEP:    mode_d = PAUSE;
            default: mode_d = RUN;
        endcase

        if (press[BTN_DEF]) begin
            load_d     = 1'b1;
            load_val_d = LED_DEFAULT;
        end else if (press[BTN_LOAD]) begin
            load_d     = 1'b1;
            load_val_d = sw;
        end

        // A load wins the output cycle and restarts the step period.
        if (load_d) begin
            step_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= RUN;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            load_q     <= 1'b0;
            dir_q      <= 1'b0;
            load_val_q <= '0;
        end else begin
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            load_q     <= load_d;
            dir_q      <= dir_d;
            load_val_q <= load_val_d;
        end
    end

    assign step     = step_q;
    assign load     = load_q;
    assign dir      = dir_q;
    assign load_val = load_val_q;
    assign mode     = mode_q;

endmodule
